// File: rtl/ooo_cpu_core.sv
// ooo_cpu_core
// -----------------------------------------------------------------------------
// Sequential RV32I-subset processor used as the simulation top level. Each
// instruction takes three clocks: FETCH, EXECUTE, WRITEBACK. The instruction
// memory is loaded from outside through hierarchical writes and is never
// written here.
//
// Hierarchical state that outside code reads directly:
//   instruction_mem[0:255], data_mem[0:DMEM_WORDS-1], regs[0:31], pc, halted
//
// Ports:
//   clk      in  1  system clock, all state changes on the rising edge
//   reset_n  in  1  synchronous active-low reset
//
// Parameters:
//   PC_MAX      number of instruction words; fetching word PC_MAX or above halts
//   DMEM_WORDS  data memory depth in 32-bit words
// -----------------------------------------------------------------------------
module ooo_cpu_core #(
  parameter int PC_MAX     = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset_n
);

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    WRITEBACK
  } stage_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int          DMEM_AW  = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] PC_LIMIT = 32'(PC_MAX);

  // Architectural state, named for direct hierarchical access.
  logic [31:0] instruction_mem [0:255];
  logic [31:0] data_mem [0:DMEM_WORDS-1];
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic        halted;

  // Pipeline-free sequencing state.
  stage_e      stage_q, stage_d;
  logic [31:0] ir_q;
  logic [31:0] result_q, result_d;    // value for rd, or byte address for LW/SW
  logic [31:0] next_pc_q, next_pc_d;
  logic        wr_en_q, wr_en_d;
  logic        load_q, load_d;
  logic        store_q, store_d;

  // Instruction fields.
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        branch_taken;
  logic [DMEM_AW-1:0] dmem_idx;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // regs[0] is never written, so it always reads as zero.
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  // Address bits 1:0 are ignored; the word index wraps at DMEM_WORDS.
  assign dmem_idx = DMEM_AW'(32'(result_q[9:2]) % 32'(DMEM_WORDS));

  // Shared ALU for R-type and I-type. 'alt' selects SUB / SRA.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it holding a latched value.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rs1_val == rs2_val);
      3'b001:  branch_taken = (rs1_val != rs2_val);
      3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      default: branch_taken = 1'b0;  // unsigned branches are not supported: NOP
    endcase
  end

  // EXECUTE decode. pc still holds the address of the current instruction.
  // Unsupported opcodes and funct3 values keep the defaults, i.e. act as NOP.
  always_comb begin
    result_d  = '0;
    next_pc_d = pc + 32'd4;
    wr_en_d   = 1'b0;
    load_d    = 1'b0;
    store_d   = 1'b0;
    case (opcode)
      OP_LUI: begin
        result_d = imm_u;
        wr_en_d  = 1'b1;
      end
      OP_AUIPC: begin
        result_d = pc + imm_u;
        wr_en_d  = 1'b1;
      end
      OP_JAL: begin
        result_d  = pc + 32'd4;
        wr_en_d   = 1'b1;
        next_pc_d = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          result_d  = pc + 32'd4;
          wr_en_d   = 1'b1;
          next_pc_d = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (branch_taken) next_pc_d = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          result_d = rs1_val + imm_i;
          load_d   = 1'b1;
          wr_en_d  = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          result_d = rs1_val + imm_s;
          store_d  = 1'b1;
        end
      end
      OP_IMM: begin
        // SLTIU is not part of the supported set. Only shifts use bit 30 as a
        // selector; for ADDI it is an immediate bit.
        if (funct3 != 3'b011) begin
          result_d = alu(funct3, (funct3 == 3'b101) && ir_q[30], rs1_val, imm_i);
          wr_en_d  = 1'b1;
        end
      end
      OP_REG: begin
        result_d = alu(funct3, ir_q[30], rs1_val, rs2_val);
        wr_en_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM next state: one stage per clock, wrapping back to FETCH.
  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      FETCH:     stage_d = EXECUTE;
      EXECUTE:   stage_d = WRITEBACK;
      WRITEBACK: stage_d = FETCH;
      default:   stage_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and process ordering cannot matter.
  always_ff @(posedge clk) begin
    if (!reset_n)    stage_q <= FETCH;
    else if (!halted) stage_q <= stage_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Reset abandons any in-flight instruction: nothing below runs this edge.
      pc        <= '0;
      halted    <= 1'b0;
      ir_q      <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
      wr_en_q   <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      // NOTE: data_mem is cleared by reset, which rules out a plain RAM macro;
      // instruction_mem is deliberately left out so its contents survive reset.
      for (int i = 0; i < DMEM_WORDS; i++) data_mem[i] <= '0;
    end else if (!halted) begin
      case (stage_q)
        FETCH: ir_q <= instruction_mem[pc[9:2]];
        EXECUTE: begin
          result_q  <= result_d;
          next_pc_q <= next_pc_d;
          wr_en_q   <= wr_en_d;
          load_q    <= load_d;
          store_q   <= store_d;
        end
        WRITEBACK: begin
          if (wr_en_q && (rd != 5'd0)) regs[rd] <= load_q ? data_mem[dmem_idx] : result_q;
          if (store_q) data_mem[dmem_idx] <= rs2_val;
          pc <= next_pc_q;
          // The next fetch would be out of range, so stop here; halted is then
          // visible on the same edge the pc moves past the end.
          halted <= ({2'b00, next_pc_q[31:2]} >= PC_LIMIT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ooo_cpu_core.sv
// Testbench for ooo_cpu_core: directed programs with hand-derived results,
// then random programs compared against an instruction-level reference model.
module tb_ooo_cpu_core;

  localparam int PC_MAX     = 256;
  localparam int DMEM_WORDS = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ooo_cpu_core #(.PC_MAX(PC_MAX), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Program representation (mnemonic level) and encoder
  // ---------------------------------------------------------------------------
  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_SLT, M_SLTU,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLLI, M_SRLI, M_SRAI,
    M_LUI, M_AUIPC, M_LW, M_SW, M_BEQ, M_BNE, M_BLT, M_BGE, M_JAL, M_JALR,
    M_NOP
  } mn_e;

  typedef struct packed {
    mn_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } insn_t;

  insn_t prog [0:255];

  function automatic insn_t mk(mn_e op, int rd, int rs1, int rs2, logic [31:0] imm);
    mk.op  = op;
    mk.rd  = 5'(rd);
    mk.rs1 = 5'(rs1);
    mk.rs2 = 5'(rs2);
    mk.imm = imm;
  endfunction

  function automatic logic [31:0] encode(insn_t in);
    logic [31:0] im;
    im = in.imm;
    case (in.op)
      M_ADD:   encode = {7'h00, in.rs2, in.rs1, 3'b000, in.rd, 7'b0110011};
      M_SUB:   encode = {7'h20, in.rs2, in.rs1, 3'b000, in.rd, 7'b0110011};
      M_SLL:   encode = {7'h00, in.rs2, in.rs1, 3'b001, in.rd, 7'b0110011};
      M_SLT:   encode = {7'h00, in.rs2, in.rs1, 3'b010, in.rd, 7'b0110011};
      M_SLTU:  encode = {7'h00, in.rs2, in.rs1, 3'b011, in.rd, 7'b0110011};
      M_XOR:   encode = {7'h00, in.rs2, in.rs1, 3'b100, in.rd, 7'b0110011};
      M_SRL:   encode = {7'h00, in.rs2, in.rs1, 3'b101, in.rd, 7'b0110011};
      M_SRA:   encode = {7'h20, in.rs2, in.rs1, 3'b101, in.rd, 7'b0110011};
      M_OR:    encode = {7'h00, in.rs2, in.rs1, 3'b110, in.rd, 7'b0110011};
      M_AND:   encode = {7'h00, in.rs2, in.rs1, 3'b111, in.rd, 7'b0110011};
      M_ADDI:  encode = {im[11:0], in.rs1, 3'b000, in.rd, 7'b0010011};
      M_SLTI:  encode = {im[11:0], in.rs1, 3'b010, in.rd, 7'b0010011};
      M_XORI:  encode = {im[11:0], in.rs1, 3'b100, in.rd, 7'b0010011};
      M_ORI:   encode = {im[11:0], in.rs1, 3'b110, in.rd, 7'b0010011};
      M_ANDI:  encode = {im[11:0], in.rs1, 3'b111, in.rd, 7'b0010011};
      M_SLLI:  encode = {7'h00, im[4:0], in.rs1, 3'b001, in.rd, 7'b0010011};
      M_SRLI:  encode = {7'h00, im[4:0], in.rs1, 3'b101, in.rd, 7'b0010011};
      M_SRAI:  encode = {7'h20, im[4:0], in.rs1, 3'b101, in.rd, 7'b0010011};
      M_LUI:   encode = {im[31:12], in.rd, 7'b0110111};
      M_AUIPC: encode = {im[31:12], in.rd, 7'b0010111};
      M_LW:    encode = {im[11:0], in.rs1, 3'b010, in.rd, 7'b0000011};
      M_SW:    encode = {im[11:5], in.rs2, in.rs1, 3'b010, im[4:0], 7'b0100011};
      M_BEQ:   encode = {im[12], im[10:5], in.rs2, in.rs1, 3'b000, im[4:1], im[11], 7'b1100011};
      M_BNE:   encode = {im[12], im[10:5], in.rs2, in.rs1, 3'b001, im[4:1], im[11], 7'b1100011};
      M_BLT:   encode = {im[12], im[10:5], in.rs2, in.rs1, 3'b100, im[4:1], im[11], 7'b1100011};
      M_BGE:   encode = {im[12], im[10:5], in.rs2, in.rs1, 3'b101, im[4:1], im[11], 7'b1100011};
      M_JAL:   encode = {im[20], im[10:1], im[11], im[19:12], in.rd, 7'b1101111};
      M_JALR:  encode = {im[11:0], in.rs1, 3'b000, in.rd, 7'b1100111};
      default: encode = 32'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: executes the mnemonic program one instruction at a time
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dmem [0:255];

  task automatic model_run(output int steps, output logic [31:0] final_pc);
    logic [31:0] pc_m, a, b, v, nxt, addr;
    logic        wr;
    insn_t       in;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
    pc_m  = '0;
    steps = 0;
    while ((pc_m >> 2) < PC_MAX && steps < 5000) begin
      in   = prog[pc_m >> 2];
      a    = m_regs[in.rs1];
      b    = m_regs[in.rs2];
      nxt  = pc_m + 4;
      v    = '0;
      wr   = 1'b1;
      addr = a + in.imm;
      case (in.op)
        M_ADD:   v = a + b;
        M_SUB:   v = a - b;
        M_AND:   v = a & b;
        M_OR:    v = a | b;
        M_XOR:   v = a ^ b;
        M_SLL:   v = a << b[4:0];
        M_SRL:   v = a >> b[4:0];
        M_SRA:   v = $unsigned($signed(a) >>> b[4:0]);
        M_SLT:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        M_SLTU:  v = (a < b) ? 32'd1 : 32'd0;
        M_ADDI:  v = a + in.imm;
        M_ANDI:  v = a & in.imm;
        M_ORI:   v = a | in.imm;
        M_XORI:  v = a ^ in.imm;
        M_SLTI:  v = ($signed(a) < $signed(in.imm)) ? 32'd1 : 32'd0;
        M_SLLI:  v = a << in.imm[4:0];
        M_SRLI:  v = a >> in.imm[4:0];
        M_SRAI:  v = $unsigned($signed(a) >>> in.imm[4:0]);
        M_LUI:   v = in.imm;
        M_AUIPC: v = pc_m + in.imm;
        M_LW:    v = m_dmem[(addr >> 2) % 256];
        M_SW:    begin m_dmem[(addr >> 2) % 256] = b; wr = 1'b0; end
        M_BEQ:   begin if (a == b) nxt = pc_m + in.imm; wr = 1'b0; end
        M_BNE:   begin if (a != b) nxt = pc_m + in.imm; wr = 1'b0; end
        M_BLT:   begin if ($signed(a) < $signed(b)) nxt = pc_m + in.imm; wr = 1'b0; end
        M_BGE:   begin if ($signed(a) >= $signed(b)) nxt = pc_m + in.imm; wr = 1'b0; end
        M_JAL:   begin v = pc_m + 4; nxt = pc_m + in.imm; end
        M_JALR:  begin v = pc_m + 4; nxt = addr & ~32'd1; end
        default: wr = 1'b0;
      endcase
      if (wr && in.rd != 0) m_regs[in.rd] = v;
      pc_m = nxt;
      steps++;
    end
    final_pc = pc_m;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge, sampling there too)
  // ---------------------------------------------------------------------------
  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = mk(M_NOP, 0, 0, 0, 32'h0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.instruction_mem[i] = encode(prog[i]);
  endtask

  // Leaves the bench at a falling edge with reset_n high; the next rising
  // edge is the first fetch at pc=0.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag, output int cycles);
    cycles = 0;
    while (!dut.halted && cycles < 4000) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    check({tag, "_halt_reached"}, 32'(dut.halted), 32'd1);
  endtask

  function automatic logic [31:0] sx12(logic [31:0] r);
    sx12 = {{20{r[11]}}, r[11:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cycles, steps, n;
    logic [31:0] fpc, r;
    mn_e op;

    // 1. Reset and idle on an all-zero program.
    clear_prog();
    load_prog();
    apply_reset();
    check("t1_pc_reset", dut.pc, 32'h0);
    check("t1_halted_reset", 32'(dut.halted), 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("t1_x%0d_reset", i), dut.regs[i], 32'h0);
    for (int c = 1; c <= 3 * PC_MAX; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3) check("t1_pc_after_3", dut.pc, 32'd4);
      if (c == 6) check("t1_pc_after_6", dut.pc, 32'd8);
      if (c == 3 * PC_MAX - 1) check("t1_not_halted_early", 32'(dut.halted), 32'd0);
      if (c == 3 * PC_MAX) begin
        check("t1_halted_on_time", 32'(dut.halted), 32'd1);
        check("t1_pc_at_halt", dut.pc, 32'(4 * PC_MAX));
      end
    end
    step(9);
    check("t1_pc_frozen", dut.pc, 32'(4 * PC_MAX));

    // 2. ALU sequence.
    clear_prog();
    prog[0] = mk(M_ADDI, 1, 0, 0, 32'd5);
    prog[1] = mk(M_ADDI, 2, 0, 0, -32'sd3);
    prog[2] = mk(M_ADD,  3, 1, 2, 32'h0);
    prog[3] = mk(M_SUB,  4, 2, 1, 32'h0);
    prog[4] = mk(M_SLT,  5, 2, 1, 32'h0);
    prog[5] = mk(M_SRAI, 6, 2, 0, 32'd1);
    load_prog();
    apply_reset();
    step(17);
    check("t2_x6_not_yet", dut.regs[6], 32'h0);
    step(1);
    check("t2_x1", dut.regs[1], 32'd5);
    check("t2_x2", dut.regs[2], 32'hFFFFFFFD);
    check("t2_x3", dut.regs[3], 32'd2);
    check("t2_x4", dut.regs[4], 32'hFFFFFFF8);
    check("t2_x5", dut.regs[5], 32'd1);
    check("t2_x6", dut.regs[6], 32'hFFFFFFFE);
    check("t2_pc", dut.pc, 32'd24);

    // 3. Memory access and x0 write discard.
    clear_prog();
    prog[0] = mk(M_ADDI, 1, 0, 0, 32'h55);
    prog[1] = mk(M_SW,   0, 0, 1, 32'd8);
    prog[2] = mk(M_LW,   2, 0, 0, 32'd8);
    prog[3] = mk(M_ADDI, 0, 0, 0, 32'd7);
    load_prog();
    apply_reset();
    step(12);
    check("t3_dmem2", dut.data_mem[2], 32'h55);
    check("t3_x2", dut.regs[2], 32'h55);
    check("t3_x0", dut.regs[0], 32'h0);
    apply_reset();
    check("t3_dmem2_cleared", dut.data_mem[2], 32'h0);
    check("t3_x2_cleared", dut.regs[2], 32'h0);

    // 4. Loop and JAL.
    clear_prog();
    prog[0] = mk(M_ADDI, 7, 0, 0, 32'd4);
    prog[1] = mk(M_ADDI, 1, 1, 0, 32'd1);
    prog[2] = mk(M_BNE,  0, 1, 7, -32'sd4);
    prog[3] = mk(M_JAL,  5, 0, 0, 32'd8);
    prog[4] = mk(M_ADDI, 6, 0, 0, 32'd1);
    prog[5] = mk(M_ADDI, 8, 0, 0, 32'd2);
    load_prog();
    apply_reset();
    run_to_halt("t4", cycles);
    check("t4_x1", dut.regs[1], 32'd4);
    check("t4_x5", dut.regs[5], 32'd16);
    check("t4_x6_skipped", dut.regs[6], 32'd0);
    check("t4_x8", dut.regs[8], 32'd2);
    // 1 + 4*2 + JAL + ADDI, then NOPs from word 6 to the end.
    check("t4_cycles", 32'(cycles), 32'(3 * (11 + PC_MAX - 6)));

    // 5a. Halt boundary: last four words of instruction memory.
    clear_prog();
    prog[0] = mk(M_JAL, 0, 0, 0, 32'(4 * (PC_MAX - 4)));
    for (int i = 0; i < 4; i++) prog[PC_MAX - 4 + i] = mk(M_ADDI, i + 1, 0, 0, 32'(i + 1));
    load_prog();
    apply_reset();
    step(14);
    check("t5a_not_halted", 32'(dut.halted), 32'd0);
    step(1);
    check("t5a_halted", 32'(dut.halted), 32'd1);
    for (int i = 1; i <= 4; i++) check($sformatf("t5a_x%0d", i), dut.regs[i], 32'(i));

    // 5b. Jump beyond the end, then confirm everything stays frozen.
    clear_prog();
    prog[0] = mk(M_ADDI, 1, 0, 0, 32'd3);
    prog[1] = mk(M_JAL,  0, 0, 0, 32'(4 * PC_MAX - 4));
    load_prog();
    apply_reset();
    step(6);
    check("t5b_halted", 32'(dut.halted), 32'd1);
    step(10);
    check("t5b_pc", dut.pc, 32'(4 * PC_MAX));
    check("t5b_x1", dut.regs[1], 32'd3);
    check("t5b_x2", dut.regs[2], 32'd0);

    // 5c. Negative JALR target wraps high and halts.
    clear_prog();
    prog[0] = mk(M_ADDI, 2, 0, 0, -32'sd8);
    prog[1] = mk(M_JALR, 3, 2, 0, 32'd0);
    load_prog();
    apply_reset();
    step(6);
    check("t5c_halted", 32'(dut.halted), 32'd1);
    check("t5c_pc", dut.pc, 32'hFFFFFFF8);
    check("t5c_x3", dut.regs[3], 32'd8);

    // 6. Reset during EXECUTE and during WRITEBACK.
    clear_prog();
    prog[0] = mk(M_ADDI, 1, 0, 0, 32'd9);
    load_prog();
    apply_reset();
    @(posedge clk);              // fetch
    @(negedge clk);
    reset_n = 1'b0;
    step(1);                     // edge that would have executed
    check("t6_x1_after_exec_reset", dut.regs[1], 32'd0);
    check("t6_pc_after_exec_reset", dut.pc, 32'd0);
    reset_n = 1'b1;
    step(2);
    check("t6_x1_before_wb", dut.regs[1], 32'd0);
    step(1);
    check("t6_x1_restart", dut.regs[1], 32'd9);
    apply_reset();
    step(2);
    reset_n = 1'b0;
    step(1);                     // edge that would have written back
    check("t6_x1_after_wb_reset", dut.regs[1], 32'd0);
    check("t6_pc_after_wb_reset", dut.pc, 32'd0);
    reset_n = 1'b1;
    step(3);
    check("t6_x1_second_restart", dut.regs[1], 32'd9);

    // 7. Random programs against the reference model.
    for (int t = 0; t < 8; t++) begin
      clear_prog();
      n = $urandom_range(16, 48);
      for (int i = 0; i < n; i++) begin
        op = mn_e'(5'($urandom_range(0, 27)));
        r  = $urandom;
        prog[i] = mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), sx12(r));
        case (op)
          M_SLLI, M_SRLI, M_SRAI: prog[i].imm = 32'($urandom_range(0, 31));
          M_LUI, M_AUIPC:         prog[i].imm = r & 32'hFFFFF000;
          M_BEQ, M_BNE, M_BLT, M_BGE, M_JAL:
                                  prog[i].imm = 32'(4 * $urandom_range(1, 4));
          M_JALR: begin
            prog[i].rs1 = 5'd0;
            prog[i].imm = 32'(4 * (i + $urandom_range(1, 4)) + $urandom_range(0, 1));
          end
          default: ;
        endcase
      end
      load_prog();
      model_run(steps, fpc);
      apply_reset();
      run_to_halt($sformatf("rnd%0d", t), cycles);
      check($sformatf("rnd%0d_cycles", t), 32'(cycles), 32'(3 * steps));
      check($sformatf("rnd%0d_pc", t), dut.pc, fpc);
      for (int i = 0; i < 32; i++) check($sformatf("rnd%0d_x%0d", t, i), dut.regs[i], m_regs[i]);
      for (int i = 0; i < DMEM_WORDS; i++) check($sformatf("rnd%0d_dmem%0d", t, i), dut.data_mem[i], m_dmem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
